// File: rtl/frame_sync_mode_sequencer_if.sv
// Control-word bus between board inputs and frame_sync_mode_sequencer.
// i_*: switches, auto select, pause button, vsync; o_*: control word and status.
interface frame_sync_mode_sequencer_if;
    logic [8:0] i_im_p;
    logic       i_autoselect;
    logic       i_step_btn;
    logic       i_vsync;
    logic [8:0] o_im_p;
    logic       o_cfg_update;
    logic       o_auto_active;
    logic       o_hold;

    modport master (
        output i_im_p,
        output i_autoselect,
        output i_step_btn,
        output i_vsync,
        input  o_im_p,
        input  o_cfg_update,
        input  o_auto_active,
        input  o_hold
    );

    modport slave (
        input  i_im_p,
        input  i_autoselect,
        input  i_step_btn,
        input  i_vsync,
        output o_im_p,
        output o_cfg_update,
        output o_auto_active,
        output o_hold
    );
endinterface

// File: rtl/frame_sync_mode_sequencer.sv
// Frame-synchronous image-processor control word: manual switches or auto demo.
// Ports: clk, rst_n (sync, active-low), bus (slave modport, see interface).
module frame_sync_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FRAMES_PER_STEP = 150,
    parameter int SYNC_STAGES     = 2
) (
    input logic                         clk,
    input logic                         rst_n,
    frame_sync_mode_sequencer_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(FRAMES_PER_STEP) + 1;

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_AUTO_RUN  = 2'd1,
        ST_AUTO_HOLD = 2'd2
    } state_e;

    function automatic logic [8:0] word_of(input logic [7:0] s);
        return {s[7:6], s[5:2], 1'b0, s[1:0]};
    endfunction

    logic [8:0]             im_sync_q [SYNC_STAGES];
    logic [8:0]             im_sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] auto_sync_q, auto_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;
    logic                   vs_dly_q, vs_dly_d;
    logic                   btn_level_q, btn_level_d;
    logic [DW-1:0]          db_cnt_q, db_cnt_d;
    state_e                 state_q, state_d;
    logic [7:0]             s_q, s_d;
    logic [FW-1:0]          fc_q, fc_d;
    logic [8:0]             im_p_q, im_p_d;
    logic                   cfg_upd_q, cfg_upd_d;

    logic [8:0] im_sync;
    logic       auto_sync;
    logic       btn_sync;
    logic       vs_sync;
    logic       vs_edge;
    logic       btn_pulse;
    logic [8:0] new_word;

    assign im_sync   = im_sync_q[SYNC_STAGES-1];
    assign auto_sync = auto_sync_q[SYNC_STAGES-1];
    assign btn_sync  = btn_sync_q[SYNC_STAGES-1];
    assign vs_sync   = vs_sync_q[SYNC_STAGES-1];
    assign vs_edge   = vs_sync & ~vs_dly_q;

    // Synchronizer shift chains
    always_comb begin
        im_sync_d[0] = bus.i_im_p;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            im_sync_d[i] = im_sync_q[i-1];
        end
        auto_sync_d = {auto_sync_q[SYNC_STAGES-2:0], bus.i_autoselect};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], bus.i_step_btn};
        vs_sync_d   = {vs_sync_q[SYNC_STAGES-2:0], bus.i_vsync};
        vs_dly_d    = vs_sync;
    end

    // Debounce: count while the input disagrees with the accepted level;
    // any agreement restarts the count. Only accepted presses pulse.
    always_comb begin
        db_cnt_d    = '0;
        btn_level_d = btn_level_q;
        btn_pulse   = 1'b0;
        if (btn_sync != btn_level_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_level_d = btn_sync;
                btn_pulse   = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Mode FSM; leaving auto mode wins over a pause/resume press
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MANUAL: begin
                if (auto_sync) state_d = ST_AUTO_RUN;
            end
            ST_AUTO_RUN: begin
                if (!auto_sync)     state_d = ST_MANUAL;
                else if (btn_pulse) state_d = ST_AUTO_HOLD;
            end
            ST_AUTO_HOLD: begin
                if (!auto_sync)     state_d = ST_MANUAL;
                else if (btn_pulse) state_d = ST_AUTO_RUN;
            end
            default: state_d = ST_MANUAL;
        endcase
    end

    // Frame-synchronous word update; always uses the pre-transition state
    always_comb begin
        fc_d      = fc_q;
        s_d       = s_q;
        im_p_d    = im_p_q;
        cfg_upd_d = 1'b0;
        new_word  = im_p_q;
        if (vs_edge) begin
            case (state_q)
                ST_MANUAL: new_word = im_sync;
                ST_AUTO_RUN: begin
                    if (fc_q == FW'(FRAMES_PER_STEP - 1)) begin
                        fc_d     = '0;
                        s_d      = s_q + 8'd1;
                        new_word = word_of(s_d);
                    end else begin
                        fc_d     = fc_q + 1'b1;
                        new_word = word_of(s_q);
                    end
                end
                ST_AUTO_HOLD: new_word = word_of(s_q);
                default:      new_word = im_p_q;
            endcase
            im_p_d    = new_word;
            cfg_upd_d = (new_word != im_p_q);
        end
        // Entering auto mode starts a fresh frame count
        if (state_q == ST_MANUAL && auto_sync) fc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                im_sync_q[i] <= '0;
            end
            auto_sync_q <= '0;
            btn_sync_q  <= '0;
            vs_sync_q   <= '0;
            vs_dly_q    <= 1'b0;
            btn_level_q <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= ST_MANUAL;
            s_q         <= '0;
            fc_q        <= '0;
            im_p_q      <= '0;
            cfg_upd_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                im_sync_q[i] <= im_sync_d[i];
            end
            auto_sync_q <= auto_sync_d;
            btn_sync_q  <= btn_sync_d;
            vs_sync_q   <= vs_sync_d;
            vs_dly_q    <= vs_dly_d;
            btn_level_q <= btn_level_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            s_q         <= s_d;
            fc_q        <= fc_d;
            im_p_q      <= im_p_d;
            cfg_upd_q   <= cfg_upd_d;
        end
    end

    assign bus.o_im_p        = im_p_q;
    assign bus.o_cfg_update  = cfg_upd_q;
    assign bus.o_auto_active = (state_q != ST_MANUAL);
    assign bus.o_hold        = (state_q == ST_AUTO_HOLD);

endmodule

// File: tb/tb_frame_sync_mode_sequencer.sv
// Directed bench for frame_sync_mode_sequencer.
// Small debounce/frame parameters keep every scenario short.
module tb_frame_sync_mode_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk = 0;
    int   pass = 0;
    int   cfg_cnt = 0;
    int   pulse_cnt = 0;

    frame_sync_mode_sequencer_if bus_if ();

    frame_sync_mode_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .FRAMES_PER_STEP(3),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.o_cfg_update === 1'b1) cfg_cnt++;
        if (dut.btn_pulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic vs_pulse();
        bus_if.i_vsync = 1'b1;
        tick(4);
        bus_if.i_vsync = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        bus_if.i_im_p       = 9'h000;
        bus_if.i_autoselect = 1'b0;
        bus_if.i_step_btn   = 1'b0;
        bus_if.i_vsync      = 1'b0;
        tick(1);
        do_reset();
        chk++;
        if (bus_if.o_im_p !== 9'h000)
            $display("FAIL rst_im_p: got %h want 000", bus_if.o_im_p);
        else pass++;
        chk++;
        if ({bus_if.o_cfg_update, bus_if.o_auto_active, bus_if.o_hold} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000",
                     {bus_if.o_cfg_update, bus_if.o_auto_active, bus_if.o_hold});
        else pass++;
    endtask

    task automatic test_manual();
        int c0;
        c0 = cfg_cnt;
        bus_if.i_im_p = 9'h0F0;
        tick(25);
        bus_if.i_im_p = 9'h1A5;
        tick(25);
        chk++;
        if (bus_if.o_im_p !== 9'h000 || cfg_cnt != c0)
            $display("FAIL man_hold: got %h/%0d want 000/0", bus_if.o_im_p, cfg_cnt - c0);
        else pass++;
        bus_if.i_vsync = 1'b1;
        tick(2);
        chk++;
        if (bus_if.o_im_p !== 9'h000)
            $display("FAIL man_early: got %h want 000", bus_if.o_im_p);
        else pass++;
        tick(1);
        chk++;
        if (bus_if.o_im_p !== 9'h1A5 || bus_if.o_cfg_update !== 1'b1)
            $display("FAIL man_lat3: got %h/%b want 1a5/1", bus_if.o_im_p, bus_if.o_cfg_update);
        else pass++;
        tick(1);
        chk++;
        if (bus_if.o_cfg_update !== 1'b0)
            $display("FAIL man_cfg1: got %b want 0", bus_if.o_cfg_update);
        else pass++;
        tick(6);
        bus_if.i_vsync = 1'b0;
        tick(10);
    endtask

    task automatic test_auto();
        logic [8:0] exp_w [7];
        int exp_c [7];
        int c0;
        exp_w = '{9'h000, 9'h000, 9'h001, 9'h001, 9'h001, 9'h002, 9'h002};
        exp_c = '{0, 0, 1, 0, 0, 1, 0};
        do_reset();
        bus_if.i_autoselect = 1'b1;
        tick(5);
        chk++;
        if (bus_if.o_auto_active !== 1'b1 || bus_if.o_hold !== 1'b0)
            $display("FAIL auto_enter: got %b%b want 10", bus_if.o_auto_active, bus_if.o_hold);
        else pass++;
        for (int i = 0; i < 7; i++) begin
            c0 = cfg_cnt;
            vs_pulse();
            chk++;
            if (bus_if.o_im_p !== exp_w[i] || (cfg_cnt - c0) != exp_c[i])
                $display("FAIL auto_p%0d: got %h/%0d want %h/%0d", i + 1,
                         bus_if.o_im_p, cfg_cnt - c0, exp_w[i], exp_c[i]);
            else pass++;
        end
    endtask

    task automatic test_debounce_hold();
        int p0;
        int c0;
        p0 = pulse_cnt;
        bus_if.i_step_btn = 1'b1;
        tick(2);
        bus_if.i_step_btn = 1'b0;
        tick(2);
        bus_if.i_step_btn = 1'b1;
        tick(10);
        chk++;
        if (pulse_cnt - p0 != 1 || bus_if.o_hold !== 1'b1)
            $display("FAIL db_press: got %0d/%b want 1/1", pulse_cnt - p0, bus_if.o_hold);
        else pass++;
        bus_if.i_step_btn = 1'b0;
        tick(10);
        chk++;
        if (pulse_cnt - p0 != 1 || bus_if.o_hold !== 1'b1)
            $display("FAIL db_release: got %0d/%b want 1/1", pulse_cnt - p0, bus_if.o_hold);
        else pass++;
        c0 = cfg_cnt;
        repeat (6) vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h002 || cfg_cnt != c0)
            $display("FAIL hold_frozen: got %h/%0d want 002/0", bus_if.o_im_p, cfg_cnt - c0);
        else pass++;
        bus_if.i_step_btn = 1'b1;
        tick(10);
        bus_if.i_step_btn = 1'b0;
        tick(10);
        chk++;
        if (bus_if.o_hold !== 1'b0 || bus_if.o_auto_active !== 1'b1)
            $display("FAIL resume: got %b%b want 10", bus_if.o_auto_active, bus_if.o_hold);
        else pass++;
        vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h002)
            $display("FAIL resume_p1: got %h want 002", bus_if.o_im_p);
        else pass++;
        vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h003)
            $display("FAIL resume_p2: got %h want 003", bus_if.o_im_p);
        else pass++;
    endtask

    task automatic test_wrap();
        int c0;
        do_reset();
        bus_if.i_autoselect = 1'b1;
        tick(5);
        repeat (255 * 3) vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h1FB)
            $display("FAIL wrap_255: got %h want 1fb", bus_if.o_im_p);
        else pass++;
        c0 = cfg_cnt;
        repeat (3) vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h000 || cfg_cnt - c0 != 1)
            $display("FAIL wrap_0: got %h/%0d want 000/1", bus_if.o_im_p, cfg_cnt - c0);
        else pass++;
        repeat (3) vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h001)
            $display("FAIL wrap_1: got %h want 001", bus_if.o_im_p);
        else pass++;
    endtask

    task automatic test_priority();
        int p0;
        int c0;
        bus_if.i_im_p = 9'h0C3;
        tick(4);
        bus_if.i_step_btn = 1'b1;
        tick(3);
        p0 = pulse_cnt;
        bus_if.i_autoselect = 1'b0;
        tick(3);
        chk++;
        if (pulse_cnt - p0 != 1)
            $display("FAIL prio_align: got %0d pulses want 1", pulse_cnt - p0);
        else pass++;
        chk++;
        if (bus_if.o_hold !== 1'b0 || bus_if.o_auto_active !== 1'b0)
            $display("FAIL prio_state: got %b%b want 00", bus_if.o_auto_active, bus_if.o_hold);
        else pass++;
        bus_if.i_step_btn = 1'b0;
        tick(10);
        c0 = cfg_cnt;
        vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h0C3 || cfg_cnt - c0 != 1)
            $display("FAIL prio_word: got %h/%0d want 0c3/1", bus_if.o_im_p, cfg_cnt - c0);
        else pass++;
    endtask

    task automatic test_midrun_reset();
        int c0;
        do_reset();
        bus_if.i_im_p = 9'h1A5;
        bus_if.i_autoselect = 1'b1;
        tick(5);
        repeat (5) vs_pulse();
        chk++;
        if (bus_if.o_im_p !== 9'h001 || bus_if.o_auto_active !== 1'b1)
            $display("FAIL mr_pre: got %h/%b want 001/1", bus_if.o_im_p, bus_if.o_auto_active);
        else pass++;
        rst_n = 1'b0;
        bus_if.i_vsync = 1'b1;
        tick(1);
        rst_n = 1'b1;
        bus_if.i_vsync = 1'b0;
        chk++;
        if ({bus_if.o_im_p, bus_if.o_cfg_update, bus_if.o_auto_active, bus_if.o_hold} !== 12'h000)
            $display("FAIL mr_clear: got %h%b%b%b want 000000", bus_if.o_im_p,
                     bus_if.o_cfg_update, bus_if.o_auto_active, bus_if.o_hold);
        else pass++;
        c0 = cfg_cnt;
        tick(8);
        chk++;
        if (bus_if.o_im_p !== 9'h000 || cfg_cnt != c0)
            $display("FAIL mr_vsync_ign: got %h/%0d want 000/0", bus_if.o_im_p, cfg_cnt - c0);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_debounce_hold();
        test_wrap();
        test_priority();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
